loader_reset_bridge: RTL and testbench

//  Decouples data_io ioctl download writes from the SDRAM slot timing and sequences core reset/autoboot.

---
 rtl/loader_reset_bridge.sv | 267 ++++++++++++++++++++++++++
 tb/tb_loader_reset_bridge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loader_reset_bridge.sv
`default_nettype none
// ============================================================================
// Module      : loader_reset_bridge
// Description : Bridges data_io ioctl download writes onto SDRAM slot timing
//               and sequences the core reset / autoboot key.
//               - Buffers DEPTH (addr,data) pairs and issues at most one
//                 SDRAM write per mem_sync slot, holding the request for the
//                 whole slot.
//               - Holds the core in reset while loading, and for HOLD_CYCLES
//                 after a load ends or the config bus changes.
//               - Presses the autoboot key for BOOT_CYCLES after the core
//                 leaves reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_sys        in   system clock
//   reset          in   synchronous, active-high reset
//   ioctl_download in   download in progress
//   ioctl_wr       in   one-cycle write strobe
//   ioctl_addr     in   [ADDR_W] write address
//   ioctl_dout     in   [8] write data
//   mem_sync       in   one-cycle pulse at start of each SDRAM slot
//   cfg            in   [CFG_W] config bits; any change forces a reset hold
//   core_reset_in  in   other reset sources (OSD, button, sdram not ready)
//   autoboot_en    in   enable boot_key generation
//   loader_active  out  download or drain in progress (SDRAM mux select)
//   loader_we      out  SDRAM write request, held for a whole slot
//   loader_addr    out  [ADDR_W] SDRAM write address
//   loader_data    out  [8] SDRAM write data
//   core_reset     out  core reset, changes only on mem_sync
//   boot_key       out  autoboot key held
//   overflow       out  sticky; a write was dropped (cleared on new load)
//   fifo_level     out  [$clog2(DEPTH)+1] entries held
//   checksum       out  [16] sum of issued loader_data (LOADER_CHECKSUM_EN)
// Optional feature macro: LOADER_CHECKSUM_EN
// ============================================================================
module loader_reset_bridge #(
  parameter int ADDR_W      = 25,
  parameter int DEPTH       = 4,
  parameter int CFG_W       = 1,
  parameter int HOLD_CYCLES = 4095,
  parameter int BOOT_CYCLES = 32000000
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ioctl_download,
  input  logic                     ioctl_wr,
  input  logic [ADDR_W-1:0]        ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic                     mem_sync,
  input  logic [CFG_W-1:0]         cfg,
  input  logic                     core_reset_in,
  input  logic                     autoboot_en,
  output logic                     loader_active,
  output logic                     loader_we,
  output logic [ADDR_W-1:0]        loader_addr,
  output logic [7:0]               loader_data,
  output logic                     core_reset,
  output logic                     boot_key,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]              checksum
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                download_q;
  logic [CFG_W-1:0]    cfg_q;
  logic [ADDR_W-1:0]   mem_addr [DEPTH];
  logic [7:0]          mem_data [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [BOOT_W-1:0]   boot_cnt;

  logic dl_rise;
  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic pop;
  logic push;
  logic drop;
  logic cfg_changed;
  logic enter_load;
  logic enter_hold;
  logic active_nxt;

  assign dl_rise     = ioctl_download && !download_q;
  assign fifo_empty  = (level == '0);
  assign fifo_full   = (level == FULL_LVL);
  assign push_req    = ioctl_wr && ioctl_download &&
                       ((state == ST_LOAD) || (state == ST_DRAIN));
  // Only entries already stored can be popped: a push into an empty FIFO
  // waits for the following slot, there is no bypass path.
  assign pop         = mem_sync && !fifo_empty;
  // A full FIFO still accepts a write when a slot frees an entry this cycle.
  assign push        = push_req && (!fifo_full || pop);
  assign drop        = push_req && fifo_full && !pop;
  assign cfg_changed = (cfg != cfg_q);

  assign fifo_level  = level;
  assign boot_key    = autoboot_en && (boot_cnt != '0) && !core_reset;

  // --------------------------------------------------------------------------
  // FSM next state and transition strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    enter_load = 1'b0;
    enter_hold = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dl_rise) begin
          state_nxt  = ST_LOAD;
          enter_load = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!ioctl_download) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // At a slot boundary with nothing queued the outgoing write slot
        // ends and loader_we drops, so the drain is complete.
        if (mem_sync && fifo_empty) begin
          state_nxt  = ST_HOLD;
          enter_hold = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    active_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_DRAIN);
  end

  // --------------------------------------------------------------------------
  // FIFO storage (no reset needed; validity is tracked by level)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_addr[wr_ptr] <= ioctl_addr;
      mem_data[wr_ptr] <= ioctl_dout;
    end
  end

  // --------------------------------------------------------------------------
  // State, FIFO control, loader outputs, reset sequencing
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= ST_IDLE;
      // Track the current level so a download held high across reset is
      // not mistaken for a new rising edge.
      download_q    <= ioctl_download;
      cfg_q         <= cfg;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      loader_active <= 1'b0;
      loader_we     <= 1'b0;
      loader_addr   <= '0;
      loader_data   <= '0;
      overflow      <= 1'b0;
      core_reset    <= 1'b1;
      hold_cnt      <= HOLD_INIT;
      boot_cnt      <= BOOT_INIT;
    end else begin
      state         <= state_nxt;
      download_q    <= ioctl_download;
      cfg_q         <= cfg;
      loader_active <= active_nxt;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (mem_sync) begin
        if (pop) begin
          loader_we   <= 1'b1;
          loader_addr <= mem_addr[rd_ptr];
          loader_data <= mem_data[rd_ptr];
          rd_ptr      <= rd_ptr + PTR_W'(1);
        end else begin
          loader_we   <= 1'b0;
        end
      end

      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      if (enter_load) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end

      // A config change restarts the hold from the top in any state.
      if (cfg_changed || enter_hold) begin
        hold_cnt <= HOLD_INIT;
      end else if ((hold_cnt != '0) && !loader_active) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end

      // Core reset only moves on slot boundaries so the SDRAM mux and the
      // core never see a change mid-slot.
      if (mem_sync) begin
        core_reset <= core_reset_in || loader_active || (hold_cnt != '0);
      end

      if (core_reset) begin
        boot_cnt <= BOOT_INIT;
      end else if (boot_cnt != '0) begin
        boot_cnt <= boot_cnt - BOOT_W'(1);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // --------------------------------------------------------------------------
  // Running sum of every byte issued to SDRAM; a pop is exactly one issued
  // write slot.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      checksum <= 16'h0000;
    end else if (enter_load) begin
      checksum <= 16'h0000;
    end else if (pop) begin
      checksum <= checksum + {8'h00, mem_data[rd_ptr]};
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_loader_reset_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_loader_reset_bridge
// Description : Directed self-checking bench for loader_reset_bridge.
//               Slots are one mem_sync every 4 clocks (can be paused).
//               Every issued write slot is captured into a queue and
//               compared against hand-computed expected entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loader_reset_bridge;

  localparam int ADDR_W      = 25;
  localparam int DEPTH       = 4;
  localparam int CFG_W       = 1;
  localparam int HOLD_CYCLES = 16;
  localparam int BOOT_CYCLES = 100;

  logic                   clk_sys = 1'b0;
  logic                   reset = 1'b1;
  logic                   ioctl_download = 1'b0;
  logic                   ioctl_wr = 1'b0;
  logic [ADDR_W-1:0]      ioctl_addr = '0;
  logic [7:0]             ioctl_dout = 8'h00;
  logic                   mem_sync;
  logic [CFG_W-1:0]       cfg = '0;
  logic                   core_reset_in = 1'b0;
  logic                   autoboot_en = 1'b1;
  logic                   loader_active;
  logic                   loader_we;
  logic [ADDR_W-1:0]      loader_addr;
  logic [7:0]             loader_data;
  logic                   core_reset;
  logic                   boot_key;
  logic                   overflow;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]            checksum;
`endif

  always #5 clk_sys = ~clk_sys;

  // Slot generator: one mem_sync pulse every 4 clocks while enabled.
  int   sync_cnt = 0;
  logic sync_en  = 1'b1;
  assign mem_sync = sync_en && (sync_cnt == 0);

  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      sync_cnt = (sync_cnt + 1) % 4;
    end
  end

  loader_reset_bridge #(
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .CFG_W       (CFG_W),
    .HOLD_CYCLES (HOLD_CYCLES),
    .BOOT_CYCLES (BOOT_CYCLES)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_sync       (mem_sync),
    .cfg            (cfg),
    .core_reset_in  (core_reset_in),
    .autoboot_en    (autoboot_en),
    .loader_active  (loader_active),
    .loader_we      (loader_we),
    .loader_addr    (loader_addr),
    .loader_data    (loader_data),
    .core_reset     (core_reset),
    .boot_key       (boot_key),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  // Capture every write slot the DUT issues: {addr, data}.
  logic [ADDR_W+7:0] wq [$];
  logic              ms_at_edge;

  initial begin
    forever begin
      @(posedge clk_sys);
      ms_at_edge = mem_sync;
      #1;
      if (ms_at_edge && loader_we) begin
        wq.push_back({loader_addr, loader_data});
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic write_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step(1);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while (loader_active && n < 100) begin
      step(1);
      n++;
    end
    check(tag, 40'(loader_active), 40'd0);
  endtask

  task automatic wait_released(input string tag, input int limit);
    int n;
    n = 0;
    while (core_reset && n < limit) begin
      step(1);
      n++;
    end
    check(tag, 40'(core_reset), 40'd0);
  endtask

  task automatic check_entry(input string tag, input int idx,
                             input logic [ADDR_W-1:0] a, input logic [7:0] d);
    if (idx < wq.size()) begin
      check(tag, 40'(wq[idx]), 40'({a, d}));
    end
  endtask

  initial begin
    int n;

    // ---------------- 1: reset values, hold release, boot key length
    reset = 1'b1;
    step(3);
    check("rst_core_reset", 40'(core_reset), 40'd1);
    check("rst_boot_key",   40'(boot_key),   40'd0);
    check("rst_loader_we",  40'(loader_we),  40'd0);
    check("rst_active",     40'(loader_active), 40'd0);
    check("rst_overflow",   40'(overflow),   40'd0);
    check("rst_level",      40'(fifo_level), 40'd0);
    reset = 1'b0;
    step(16);
    check("hold_still_reset", 40'(core_reset), 40'd1);
    wait_released("hold_release", 8);
    n = 0;
    while (boot_key && n < 300) begin
      n++;
      step(1);
    end
    check("boot_key_len", 40'(n), 40'd100);

    // ---------------- 2: three-byte download, one per slot
    wq.delete();
    ioctl_download = 1'b1;
    step(1);
    check("load_active", 40'(loader_active), 40'd1);
    for (int i = 0; i < 3; i++) begin
      write_byte(25'h0280000 + 25'(i), 8'(8'h11 * (i + 1)));
      step(3);
    end
    ioctl_download = 1'b0;
    wait_drained("dl_drain");
    check("dl_we_at_fall", 40'(loader_we), 40'd0);
    check("dl_count", 40'(wq.size()), 40'd3);
    check_entry("dl_w0", 0, 25'h0280000, 8'h11);
    check_entry("dl_w1", 1, 25'h0280001, 8'h22);
    check_entry("dl_w2", 2, 25'h0280002, 8'h33);
    wait_released("dl_release", 100);

    // ---------------- 3: overflow with six writes and no slots
    wq.delete();
    sync_en = 1'b0;
    ioctl_download = 1'b1;
    step(1);
    for (int i = 0; i < 6; i++) begin
      write_byte(25'h100 + 25'(i), 8'(8'hA0 + i));
    end
    check("ovf_level", 40'(fifo_level), 40'd4);
    check("ovf_flag",  40'(overflow),   40'd1);
    sync_en = 1'b1;
    ioctl_download = 1'b0;
    wait_drained("ovf_drain");
    check("ovf_count", 40'(wq.size()), 40'd4);
    for (int i = 0; i < 4; i++) begin
      check_entry("ovf_w", i, 25'h100 + 25'(i), 8'(8'hA0 + i));
    end
    check("ovf_sticky", 40'(overflow), 40'd1);
    wait_released("ovf_release", 100);

    // ---------------- 5: reset during drain with 2 entries queued
    sync_en = 1'b0;
    ioctl_download = 1'b1;
    step(1);
    check("ovf_cleared", 40'(overflow), 40'd0);
    write_byte(25'h200, 8'h5A);
    write_byte(25'h201, 8'hA5);
    ioctl_download = 1'b0;
    step(2);
    check("drn_level",  40'(fifo_level),    40'd2);
    check("drn_active", 40'(loader_active), 40'd1);
    wq.delete();
    reset   = 1'b1;
    sync_en = 1'b1;
    step(2);
    reset = 1'b0;
    step(12);
    check("rdrn_writes", 40'(wq.size()),    40'd0);
    check("rdrn_level",  40'(fifo_level),   40'd0);
    check("rdrn_active", 40'(loader_active), 40'd0);
    check("rdrn_we",     40'(loader_we),    40'd0);

    // Download held high across reset: level alone must not start a load.
    ioctl_download = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(8);
    check("lvl_no_load", 40'(loader_active), 40'd0);
    ioctl_download = 1'b0;
    step(1);
    ioctl_download = 1'b1;
    step(2);
    check("edge_load", 40'(loader_active), 40'd1);
    ioctl_download = 1'b0;
    wait_drained("edge_drain");
    wait_released("edge_release", 100);

    // ---------------- 4: cfg change hold and restart
    cfg = ~cfg;
    n = 0;
    while (!core_reset && n < 8) begin
      step(1);
      n++;
    end
    check("cfg_reset_rise", 40'(core_reset), 40'd1);
    if (n < 8) begin
      step(8 - n);
    end
    cfg = ~cfg;
    step(17);
    check("cfg_restart_hold", 40'(core_reset), 40'd1);
    wait_released("cfg_release", 6);

`ifdef LOADER_CHECKSUM_EN
    // ---------------- 6: checksum of issued bytes
    ioctl_download = 1'b1;
    step(1);
    write_byte(25'h300, 8'hFF);
    step(3);
    write_byte(25'h301, 8'h02);
    step(3);
    ioctl_download = 1'b0;
    wait_drained("cks_drain");
    check("cks_sum", 40'(checksum), 40'h0101);
    wait_released("cks_release", 100);
    ioctl_download = 1'b1;
    step(2);
    check("cks_clear", 40'(checksum), 40'h0000);
    ioctl_download = 1'b0;
    wait_drained("cks_drain2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
